// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
// Holds the FSM state codes, the opcode constants, the ALUOp codes used by
// both the main controller and the ALU decoder, the mux-select encodings,
// and the packed control word produced by the output ROM.
package mips_ctrl_pkg;

    // State codes are fixed so the State debug port is stable across builds.
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11,
        IDLE   = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic       branch;
        logic       pc_write;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [1:0] alu_op;
    } ctrl_t;

    // True for every opcode the controller knows how to sequence.
    function automatic logic is_known_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_output_rom.sv
// State-to-control-word table for the multicycle main controller.
// Ports:
//   state - current FSM state code (4 bits)
//   ctrl  - datapath strobes and mux selects for that state
// Purely combinational; codes with no entry (IDLE, 13-15) yield an all-zero word.
module mc_output_rom
    import mips_ctrl_pkg::*;
(
    input  logic [3:0] state,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMMSH;
            end
            MEMADR, ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            MEMRD: begin
                ctrl.iord = 1'b1;
            end
            MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.branch    = 1'b1;
            end
            ADDIWB: begin
                ctrl.reg_write = 1'b1;
            end
            JUMP: begin
                ctrl.pc_src   = PCSRC_JUMP;
                ctrl.pc_write = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_main_controller.sv
// Main controller FSM for a multicycle MIPS datapath.
// Ports:
//   clk, rst_n         - clock and asynchronous active-low reset
//   Op, Zero           - opcode from the instruction register, ALU zero flag
//   IorD .. PCWrite    - single-bit datapath strobes/selects
//   ALUSrcB, PCSrc     - 2-bit mux selects
//   ALUOp              - ALU decoder operation class
//   PCEn               - PC register enable (PCWrite or taken branch)
//   Illegal            - unrecognised opcode seen in DECODE
//   State              - current state code, for debug
// Reset drops straight into IDLE, whose control word is all zero, so any
// in-flight write strobe is released without waiting for a clock edge.
module multicycle_main_controller
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic       Zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       Branch,
    output logic       PCWrite,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [1:0] ALUOp,
    output logic       PCEn,
    output logic       Illegal,
    output logic [3:0] State
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Op only steers the sequence in DECODE and MEMADR; every other state
    // advances regardless of what the instruction register holds.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            IDLE:   state_d = FETCH;
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                if (Op == OP_LW) begin
                    state_d = MEMRD;
                end else if (Op == OP_SW) begin
                    state_d = MEMWR;
                end else begin
                    state_d = FETCH;
                end
            end
            MEMRD:  state_d = MEMWB;
            EXEC:   state_d = ALUWB;
            ADDIEX: state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    mc_output_rom u_rom (
        .state (state_q),
        .ctrl  (ctrl)
    );

    assign IorD     = ctrl.iord;
    assign MemWrite = ctrl.mem_write;
    assign IRWrite  = ctrl.ir_write;
    assign RegDst   = ctrl.reg_dst;
    assign MemtoReg = ctrl.mem_to_reg;
    assign RegWrite = ctrl.reg_write;
    assign ALUSrcA  = ctrl.alu_src_a;
    assign Branch   = ctrl.branch;
    assign PCWrite  = ctrl.pc_write;
    assign ALUSrcB  = ctrl.alu_src_b;
    assign PCSrc    = ctrl.pc_src;
    assign ALUOp    = ctrl.alu_op;
    assign State    = state_q;

    assign PCEn    = ctrl.pc_write | (ctrl.branch & Zero);
    assign Illegal = (state_q == DECODE) && !is_known_op(Op);

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Self-checking bench for multicycle_main_controller.
// A reference model tracks the expected state as a per-instruction queue of
// remaining steps and derives expected outputs from the state table.
module tb_multicycle_main_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Op;
    logic       Zero;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
    logic       ALUSrcA, Branch, PCWrite, PCEn, Illegal;
    logic [1:0] ALUSrcB, PCSrc, ALUOp;
    logic [3:0] State;

    multicycle_main_controller dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Op       (Op),
        .Zero     (Zero),
        .IorD     (IorD),
        .MemWrite (MemWrite),
        .IRWrite  (IRWrite),
        .RegDst   (RegDst),
        .MemtoReg (MemtoReg),
        .RegWrite (RegWrite),
        .ALUSrcA  (ALUSrcA),
        .Branch   (Branch),
        .PCWrite  (PCWrite),
        .ALUSrcB  (ALUSrcB),
        .PCSrc    (PCSrc),
        .ALUOp    (ALUOp),
        .PCEn     (PCEn),
        .Illegal  (Illegal),
        .State    (State)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;

    int pass_count = 0;
    int check_count = 0;

    int m_state;
    int pending[$];
    int cycle_num = 0;
    int fetch_cycle = 0;
    bit fetch_valid = 0;
    logic [5:0] last_instr_op = 6'b111111;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic bit known_op(input logic [5:0] op);
        return op inside {LW, SW, RT, BEQ, ADDI, J};
    endfunction

    // Control word in the order {IorD,MemWrite,IRWrite,RegDst,MemtoReg,
    // RegWrite,ALUSrcA,Branch,PCWrite,ALUSrcB,PCSrc,ALUOp}.
    function automatic logic [14:0] exp_word(input int s);
        bit iord = 0, mw = 0, irw = 0, rd = 0, mtr = 0, rw = 0, asa = 0, br = 0, pcw = 0;
        logic [1:0] srcb = 2'b00, pcsrc = 2'b00, aluop = 2'b00;
        case (s)
            0:    begin irw = 1; pcw = 1; srcb = 2'b01; end
            1:    srcb = 2'b11;
            2, 9: begin asa = 1; srcb = 2'b10; end
            3:    iord = 1;
            4:    begin mtr = 1; rw = 1; end
            5:    begin iord = 1; mw = 1; end
            6:    begin asa = 1; aluop = 2'b10; end
            7:    begin rd = 1; rw = 1; end
            8:    begin asa = 1; aluop = 2'b01; pcsrc = 2'b01; br = 1; end
            10:   rw = 1;
            11:   begin pcsrc = 2'b10; pcw = 1; end
            default: ;
        endcase
        return {iord, mw, irw, rd, mtr, rw, asa, br, pcw, srcb, pcsrc, aluop};
    endfunction

    function automatic int exp_cycles(input logic [5:0] op);
        case (op)
            LW: return 5;
            SW, RT, ADDI: return 4;
            BEQ, J: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [14:0] dut_word();
        return {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                Branch, PCWrite, ALUSrcB, PCSrc, ALUOp};
    endfunction

    // Drive inputs at the negedge and compare once they have settled.
    task automatic checkState(input logic [5:0] op, input logic z);
        Op = op;
        Zero = z;
        #1;
        checkOutput("state", 32'(State), 32'(m_state));
        checkOutput("ctrl_word", 32'(dut_word()), 32'(exp_word(m_state)));
        checkOutput("pcen", 32'(PCEn),
                    32'((m_state == 0 || m_state == 11 || (m_state == 8 && z)) ? 1 : 0));
        checkOutput("illegal", 32'(Illegal), 32'((m_state == 1 && !known_op(op)) ? 1 : 0));
        if (State == 4'd0) begin
            if (fetch_valid) begin
                checkOutput("instr_cycles", 32'(cycle_num - fetch_cycle), 32'(exp_cycles(last_instr_op)));
            end
            fetch_valid = 1;
            fetch_cycle = cycle_num;
        end
        if (m_state == 1) begin
            last_instr_op = op;
        end
    endtask

    task automatic stepClock(input logic [5:0] op);
        @(posedge clk);
        cycle_num++;
        if (m_state == 12) begin
            m_state = 0;
        end else if (m_state == 0) begin
            m_state = 1;
        end else begin
            if (m_state == 1) begin
                case (op)
                    LW:      pending = '{2, 3, 4};
                    SW:      pending = '{2, 5};
                    RT:      pending = '{6, 7};
                    BEQ:     pending = '{8};
                    ADDI:    pending = '{9, 10};
                    J:       pending = '{11};
                    default: pending.delete();
                endcase
            end
            m_state = (pending.size() > 0) ? pending.pop_front() : 0;
        end
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic z);
        checkState(op, z);
        stepClock(op);
    endtask

    // Assert reset partway through the low clock phase and check that
    // everything collapses to IDLE with no strobes before the next edge.
    task automatic doReset();
        #2;
        rst_n = 1'b0;
        Zero = 1'b1;
        Op = 6'b111111;
        #1;
        checkOutput("rst_state", 32'(State), 32'd12);
        checkOutput("rst_word", 32'(dut_word()), 32'd0);
        checkOutput("rst_pcen", 32'(PCEn), 32'd0);
        checkOutput("rst_illegal", 32'(Illegal), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rst_hold_state", 32'(State), 32'd12);
        @(negedge clk);
        rst_n = 1'b1;
        m_state = 12;
        pending.delete();
        fetch_valid = 0;
    endtask

    // Run one instruction from the current model state back to FETCH.
    // Op is held through DECODE and MEMADR and scrambled elsewhere.
    // abort_at >= 0 injects a reset at that step instead of finishing.
    task automatic runInstr(input logic [5:0] op, input int zb, input int abort_at);
        int step = 0;
        logic z;
        if (m_state == 12) begin
            applyStimulus(op, 1'($urandom));
        end
        for (int n = 0; n < 8; n++) begin
            if (n > 0 && m_state == 0) begin
                return;
            end
            z = (zb >= 0 && m_state == 8) ? 1'(zb) : 1'($urandom);
            if (step == abort_at) begin
                checkState(op, z);
                doReset();
                return;
            end
            if (m_state == 0 || m_state == 1 || m_state == 2) begin
                applyStimulus(op, z);
            end else begin
                applyStimulus(6'($urandom), z);
            end
            step++;
        end
        checkOutput("instr_timeout", 32'(m_state), 32'd0);
    endtask

    function automatic logic [5:0] rand_op();
        case ($urandom_range(0, 6))
            0: return LW;
            1: return SW;
            2: return RT;
            3: return BEQ;
            4: return ADDI;
            5: return J;
            default: return 6'($urandom);
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        Op = LW;
        Zero = 1'b0;
        m_state = 12;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("por_state", 32'(State), 32'd12);
        checkOutput("por_word", 32'(dut_word()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: lw from reset, beq taken/not taken, R-type, illegal, j.
        runInstr(LW, -1, -1);
        runInstr(BEQ, 1, -1);
        runInstr(BEQ, 0, -1);
        runInstr(RT, -1, -1);
        runInstr(6'b111111, -1, -1);
        runInstr(ADDI, -1, -1);
        runInstr(J, -1, -1);
        // Reset while in MEMWR (FETCH, DECODE, MEMADR, then MEMWR).
        runInstr(SW, -1, 3);
        runInstr(SW, -1, -1);

        for (int i = 0; i < 200; i++) begin
            runInstr(rand_op(), -1, ($urandom_range(0, 14) == 0) ? int'($urandom_range(0, 4)) : -1);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
